// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
// The optional timeout support is enabled with SYSID_CHECK_TIMEOUT_EN.
package sysid_check_pkg;

    localparam int unsigned SYSID_DATA_W  = 32;
    localparam logic        SYSID_ADDR_ID = 1'b0;
    localparam logic        SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_WAIT_ID,
        ST_RD_TS,
        ST_WAIT_TS,
        ST_FIN
    } sysid_state_t;

endpackage

// File: rtl/sysid_check_timer.sv
// Clearable up-counter that raises o_terminal in the cycle the LIMIT-th cycle elapses.
// Only instantiated when SYSID_CHECK_TIMEOUT_EN is defined.
module sysid_check_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_terminal
);

    logic [31:0] r_count;

    // Terminal while the cycle in progress is the LIMIT-th since the last clear.
    assign o_terminal = ({1'b0, r_count} + 33'd1) >= {1'b0, LIMIT};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!o_terminal) begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM reader that fetches the system ID and build timestamp and compares them.
// Define SYSID_CHECK_TIMEOUT_EN to add a per-read timeout that aborts with err_timeout.
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter bit          USE_RDV        = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [SYSID_DATA_W-1:0] id_value,
    output logic [SYSID_DATA_W-1:0] ts_value,
    output logic                    err_timeout,
    output logic                    avm_address,
    output logic                    avm_read,
    input  logic                    avm_waitrequest,
    input  logic                    avm_readdatavalid,
    input  logic [SYSID_DATA_W-1:0] avm_readdata
);

    sysid_state_t r_state;
    logic         w_accept;
    logic         w_abort;
    logic         w_id_ok;

    assign w_accept = avm_read && !avm_waitrequest;
    assign w_id_ok  = (id_value == EXPECTED_ID);

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic w_timed;
    logic w_progress;
    logic w_tmr_term;

    assign w_timed    = (r_state == ST_RD_ID) || (r_state == ST_WAIT_ID) ||
                        (r_state == ST_RD_TS) || (r_state == ST_WAIT_TS);
    assign w_progress = (((r_state == ST_RD_ID) || (r_state == ST_RD_TS)) && w_accept) ||
                        (((r_state == ST_WAIT_ID) || (r_state == ST_WAIT_TS)) && avm_readdatavalid);
    // Data arriving in the terminal cycle still wins over the abort.
    assign w_abort    = w_timed && !w_progress && w_tmr_term;

    sysid_check_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_clear    (!w_timed || w_progress),
        .o_terminal (w_tmr_term)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_timeout <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            err_timeout <= 1'b0;
        end else if (w_abort) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign w_abort     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
        end else begin
            done <= 1'b0;
            if (w_abort) begin
                avm_read <= 1'b0;
                pass     <= 1'b0;
                done     <= 1'b1;
                r_state  <= ST_FIN;
            end else begin
                case (r_state)
                    ST_IDLE: if (start) begin
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        r_state     <= ST_RD_ID;
                    end
                    ST_RD_ID: if (w_accept) begin
                        if (USE_RDV) begin
                            avm_read <= 1'b0;
                            r_state  <= ST_WAIT_ID;
                        end else begin
                            id_value    <= avm_readdata;
                            avm_address <= SYSID_ADDR_TS;
                            r_state     <= ST_RD_TS;
                        end
                    end
                    ST_WAIT_ID: if (avm_readdatavalid) begin
                        id_value    <= avm_readdata;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_TS;
                        r_state     <= ST_RD_TS;
                    end
                    ST_RD_TS: if (w_accept) begin
                        avm_read <= 1'b0;
                        if (USE_RDV) begin
                            r_state <= ST_WAIT_TS;
                        end else begin
                            ts_value <= avm_readdata;
                            pass     <= w_id_ok && (avm_readdata == EXPECTED_TS);
                            done     <= 1'b1;
                            r_state  <= ST_FIN;
                        end
                    end
                    ST_WAIT_TS: if (avm_readdatavalid) begin
                        ts_value <= avm_readdata;
                        pass     <= w_id_ok && (avm_readdata == EXPECTED_TS);
                        done     <= 1'b1;
                        r_state  <= ST_FIN;
                    end
                    ST_FIN: begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        busy     <= 1'b0;
                        avm_read <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized bench for sysid_check_master: one instance per readdatavalid mode, checked
// every cycle against a timeline model; define SYSID_CHECK_TIMEOUT_EN to cover the timeout.
module tb_sysid_check_master;

    localparam logic [31:0] EID = 32'h0000_0000;
    localparam logic [31:0] ETS = 32'h618A_160C;
    localparam int          TMO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        pass_s  [2];
    logic        err_s   [2];
    logic        addr_s  [2];
    logic        read_s  [2];
    logic        wr_s    [2];
    logic        rdv_s   [2];
    logic [31:0] id_s    [2];
    logic [31:0] ts_s    [2];
    logic [31:0] rdata_s [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sysid_check_master #(
            .EXPECTED_ID    (EID),
            .EXPECTED_TS    (ETS),
            .USE_RDV        (g == 1),
            .TIMEOUT_CYCLES (TMO)
        ) u_dut (
            .clock             (clock),
            .reset             (reset),
            .start             (start_s[g]),
            .busy              (busy_s[g]),
            .done              (done_s[g]),
            .pass              (pass_s[g]),
            .id_value          (id_s[g]),
            .ts_value          (ts_s[g]),
            .err_timeout       (err_s[g]),
            .avm_address       (addr_s[g]),
            .avm_read          (read_s[g]),
            .avm_waitrequest   (wr_s[g]),
            .avm_readdatavalid (rdv_s[g]),
            .avm_readdata      (rdata_s[g])
        );
    end

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Scenario of the current run plus values held since the last completed check.
    int          m_t0 [2], m_s0 [2], m_s1 [2], m_d [2], last_done_k [2];
    bit          m_act [2], m_to [2], h_pass [2], h_err [2];
    logic [31:0] m_w0 [2], m_w1 [2], h_id [2], h_ts [2];
    int          stall_cnt [2], rdv_cnt [2];
    bit          rdv_addr [2];

    task automatic chk1(input string nm, input int i, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cyc=%0d got=%b want=%b", nm, i, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic int t_done(input int i);
        if (m_to[i]) return TMO + 1;
        return 3 + m_s0[i] + m_s1[i] + ((i == 1) ? 2 * m_d[i] : 0);
    endfunction

    function automatic bit exp_read(input int i, input int k, output bit a);
        int a1;
        a1 = 2 + m_s0[i] + ((i == 1) ? m_d[i] : 0);
        a  = 1'b0;
        if (m_to[i]) return (k >= 1) && (k <= TMO);
        if (k >= 1 && k <= 1 + m_s0[i]) return 1'b1;
        if (k >= a1 && k <= a1 + m_s1[i]) begin
            a = 1'b1;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_inst(input int i);
        int k;
        int td;
        bit ea;
        bit er;
        k  = m_act[i] ? (cyc - m_t0[i]) : -1;
        td = t_done(i);
        if (m_act[i] && k >= 1 && k <= td) begin
            chk1("busy", i, busy_s[i], 1'b1);
            chk1("done", i, done_s[i], k == td);
            er = exp_read(i, k, ea);
            chk1("avm_read", i, read_s[i], er);
            if (er) chk1("avm_address", i, addr_s[i], ea);
            if (done_s[i] === 1'b1) last_done_k[i] = k;
            if (k == td) begin
                if (m_to[i]) begin
                    h_pass[i] = 1'b0;
                    h_err[i]  = 1'b1;
                end else begin
                    h_id[i]   = m_w0[i];
                    h_ts[i]   = m_w1[i];
                    h_pass[i] = (m_w0[i] == EID) && (m_w1[i] == ETS);
                    h_err[i]  = 1'b0;
                end
                chk1("pass", i, pass_s[i], h_pass[i]);
                chk1("err_timeout", i, err_s[i], h_err[i]);
                chk32("id_value", i, id_s[i], h_id[i]);
                chk32("ts_value", i, ts_s[i], h_ts[i]);
                m_act[i] = 1'b0;
            end else begin
                chk1("pass_run", i, pass_s[i], 1'b0);
                chk1("err_run", i, err_s[i], 1'b0);
            end
        end else begin
            chk1("busy_idle", i, busy_s[i], 1'b0);
            chk1("done_idle", i, done_s[i], 1'b0);
            chk1("read_idle", i, read_s[i], 1'b0);
            chk1("pass_hold", i, pass_s[i], h_pass[i]);
            chk1("err_hold", i, err_s[i], h_err[i]);
            chk32("id_hold", i, id_s[i], h_id[i]);
            chk32("ts_hold", i, ts_s[i], h_ts[i]);
        end
    endtask

    initial forever begin
        @(negedge clock);
        #1;
        if (reset === 1'b0) for (int i = 0; i < 2; i++) check_inst(i);
    end

    // Responder: stalls, data, delayed readdatavalid, and junk strobes where they must be ignored.
    task automatic respond(input int i);
        int lim;
        wr_s[i]    = 1'b0;
        rdata_s[i] = $urandom;
        rdv_s[i]   = (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (i == 1) begin
            if (rdv_cnt[i] > 0) begin
                rdv_cnt[i]--;
                if (rdv_cnt[i] == 0) begin
                    rdv_s[i]   = 1'b1;
                    rdata_s[i] = rdv_addr[i] ? m_w1[i] : m_w0[i];
                end
            end else begin
                rdv_s[i] = 1'($urandom_range(0, 1));
            end
        end
        if (read_s[i] === 1'b1) begin
            lim = addr_s[i] ? m_s1[i] : m_s0[i];
            if (stall_cnt[i] < lim) begin
                wr_s[i] = 1'b1;
                stall_cnt[i]++;
            end else begin
                stall_cnt[i] = 0;
                if (i == 0) begin
                    rdata_s[i] = addr_s[i] ? m_w1[i] : m_w0[i];
                end else begin
                    rdv_cnt[i]  = m_d[i];
                    rdv_addr[i] = addr_s[i];
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clock);
        for (int i = 0; i < 2; i++) respond(i);
    end

    task automatic setup(input int i, input int s0, input int s1, input int d, input bit to,
                         input logic [31:0] w0, input logic [31:0] w1);
        m_s0[i] = s0;  m_s1[i] = s1;  m_d[i] = d;  m_to[i] = to;
        m_w0[i] = w0;  m_w1[i] = w1;
        stall_cnt[i] = 0;
        rdv_cnt[i]   = 0;
        start_s[i]   = 1'b1;
        m_t0[i]      = cyc;
        m_act[i]     = 1'b1;
    endtask

    task automatic run(input int i, input int s0, input int s1, input int d, input bit to,
                       input logic [31:0] w0, input logic [31:0] w1, input bit noisy);
        int td;
        setup(i, s0, s1, d, to, w0, w1);
        td = t_done(i);
        for (int j = 1; j <= td + 1; j++) begin
            @(negedge clock);
            start_s[i] = noisy && (j >= 2) && (j <= td);
        end
    endtask

    task automatic check_reset(input int i);
        chk1("rst_busy", i, busy_s[i], 1'b0);
        chk1("rst_done", i, done_s[i], 1'b0);
        chk1("rst_pass", i, pass_s[i], 1'b0);
        chk1("rst_err", i, err_s[i], 1'b0);
        chk1("rst_read", i, read_s[i], 1'b0);
        chk1("rst_addr", i, addr_s[i], 1'b0);
        chk32("rst_id", i, id_s[i], 32'h0);
        chk32("rst_ts", i, ts_s[i], 32'h0);
    endtask

    task automatic reset_mid(input int i);
        setup(i, 0, 0, 1, 1'b0, 32'h1234_5678, ETS);
        @(negedge clock);
        start_s[i] = 1'b0;
        @(negedge clock);
        #3;
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            m_act[j] = 1'b0;  h_pass[j] = 1'b0;  h_err[j] = 1'b0;
            h_id[j]  = '0;    h_ts[j]   = '0;    rdv_cnt[j] = 0;
        end
        #1;
        for (int j = 0; j < 2; j++) check_reset(j);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;  wr_s[i] = 1'b0;  rdv_s[i] = 1'b0;  rdata_s[i] = '0;
            m_act[i] = 1'b0;  m_to[i] = 1'b0;  m_s0[i] = 0;  m_s1[i] = 0;  m_d[i] = 1;
            m_w0[i] = '0;  m_w1[i] = '0;  h_pass[i] = 1'b0;  h_err[i] = 1'b0;
            h_id[i] = '0;  h_ts[i] = '0;  stall_cnt[i] = 0;  rdv_cnt[i] = 0;
            rdv_addr[i] = 1'b0;  last_done_k[i] = -1;  m_t0[i] = 0;
        end
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        for (int i = 0; i < 2; i++) check_reset(i);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run(0, 0, 0, 1, 1'b0, EID, ETS, 1'b0);
        chk32("lit_match_done_k", 0, last_done_k[0], 32'd3);
        chk1("lit_match_pass", 0, pass_s[0], 1'b1);
        chk32("lit_match_ts", 0, ts_s[0], 32'h618A160C);

        run(0, 0, 0, 1, 1'b0, EID, 32'h618A160D, 1'b0);
        chk32("lit_mis_done_k", 0, last_done_k[0], 32'd3);
        chk1("lit_mis_pass", 0, pass_s[0], 1'b0);
        chk32("lit_mis_ts", 0, ts_s[0], 32'h618A160D);

        run(0, 4, 0, 1, 1'b0, EID, ETS, 1'b0);
        chk32("lit_stall_done_k", 0, last_done_k[0], 32'd7);
        chk1("lit_stall_pass", 0, pass_s[0], 1'b1);

        run(1, 0, 0, 2, 1'b0, EID, ETS, 1'b0);
        chk32("lit_rdv_done_k", 1, last_done_k[1], 32'd7);
        chk1("lit_rdv_pass", 1, pass_s[1], 1'b1);
        repeat (6) @(negedge clock);
        chk32("lit_rdv_ts_after_stray", 1, ts_s[1], 32'h618A160C);

        run(0, 1, 1, 1, 1'b0, EID, ETS, 1'b1);
        chk32("lit_noisy_done_k", 0, last_done_k[0], 32'd5);

        reset_mid(0);
        repeat (3) @(negedge clock);

`ifdef SYSID_CHECK_TIMEOUT_EN
        run(0, 1, 0, 1, 1'b0, EID, 32'hCAFE_0001, 1'b0);
        run(0, 1000000, 0, 1, 1'b1, EID, ETS, 1'b0);
        chk32("lit_tmo_done_k", 0, last_done_k[0], 32'd9);
        chk1("lit_tmo_err", 0, err_s[0], 1'b1);
        chk1("lit_tmo_pass", 0, pass_s[0], 1'b0);
        chk1("lit_tmo_read", 0, read_s[0], 1'b0);
        chk32("lit_tmo_ts_kept", 0, ts_s[0], 32'hCAFE_0001);
        run(0, 0, 0, 1, 1'b0, EID, ETS, 1'b0);
        chk1("lit_tmo_cleared", 0, err_s[0], 1'b0);
`endif

        for (int n = 0; n < 200; n++) begin
            int          i;
            logic [31:0] w0;
            logic [31:0] w1;
            i  = int'($urandom_range(0, 1));
            w0 = ($urandom_range(0, 1) == 0) ? EID : $urandom;
            w1 = ($urandom_range(0, 1) == 0) ? ETS : $urandom;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
            run(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                1'b0, w0, w1, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

endmodule
